divisor_8bits: RTL and testbench

DIVISOR_8BITS -- requirements
Module: divisor_8bits

---
 rtl/divisor_8bits.sv | 76 +++++++
 tb/tb_divisor_8bits.sv | 112 +++++++++++
 2 files changed

// File: rtl/divisor_8bits.sv
// divisor_8bits: sequential restoring divider, one quotient bit per clock.
// Results are registered on the FIM edge, so done rises together with Q/R/div_zero.
module divisor_8bits #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         busy,
    output logic         done,
    output logic         div_zero
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIM} state_t;

    state_t        r_state, w_next;
    logic [N-1:0]  r_a, r_b, r_rem;
    logic [CW-1:0] r_cnt;
    logic [N:0]    w_sh, w_sub;
    logic          w_ge, w_go, w_zero;

    // A start coinciding with the done pulse is dropped.
    assign w_go   = start && !done;
    assign w_sh   = {r_rem, r_a[N-1]};
    assign w_sub  = w_sh - {1'b0, r_b};
    assign w_ge   = w_sh >= {1'b0, r_b};
    assign w_zero = r_b == '0;
    assign busy   = r_state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state == IDLE ? (w_go ? (B == '0 ? FIM : CALC) : IDLE) :
                 r_state == CALC ? (r_cnt == CW'(1) ? FIM : CALC) : IDLE;
    end

    // r_a holds the dividend and collects quotient bits from the LSB side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            Q        <= '0;
            R        <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= r_state == FIM;
            if (r_state == IDLE && w_go) begin
                r_a   <= A;
                r_b   <= B;
                r_rem <= '0;
                r_cnt <= CW'(N);
            end
            if (r_state == CALC) begin
                r_a   <= {r_a[N-2:0], w_ge};
                r_rem <= w_ge ? w_sub[N-1:0] : w_sh[N-1:0];
                r_cnt <= r_cnt - CW'(1);
            end
            if (r_state == FIM) begin
                Q        <= w_zero ? '1 : r_a;
                R        <= w_zero ? r_a : r_rem;
                div_zero <= w_zero;
            end
        end
    end
endmodule

// File: tb/tb_divisor_8bits.sv
// tb_divisor_8bits: directed checks of the 8-bit sequential divider plus a strided operand sweep.
module tb_divisor_8bits;
    logic       clk = 1'b0;
    logic       rst, start;
    logic [7:0] A, B, Q, R;
    logic       busy, done, div_zero;
    int         npass = 0;
    int         ntot  = 0;

    divisor_8bits #(.N(8)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .Q(Q), .R(R), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Entered and left at 1 time unit after a rising edge, in IDLE with done low.
    task automatic run(input logic [7:0] a, b, eq, er, input logic ez, input bit noisy);
        int n, nb;
        logic stable;
        logic [7:0] q0, r0;
        q0 = Q;
        r0 = R;
        stable = 1'b1;
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        nb = busy ? 1 : 0;
        n = 0;
        while (!done && n < 20) begin
            A = 8'($urandom);
            B = 8'($urandom);
            start = 1'b0;
            if (noisy && n == 3) begin
                start = 1'b1;
                A = 8'd50;
                B = 8'd5;
            end
            @(posedge clk);
            #1 n++;
            if (!done) begin
                nb += busy ? 1 : 0;
                if (Q !== q0 || R !== r0) stable = 1'b0;
            end
        end
        chk("latency", n, b == 0 ? 1 : 9);
        chk("busy_cycles", nb, b == 0 ? 1 : 9);
        chk("hold_while_busy", stable, 1);
        chk("Q", Q, eq);
        chk("R", R, er);
        chk("div_zero", div_zero, ez);
        chk("busy_at_done", busy, 0);
        A = 8'd77;
        B = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("done_width", done, 0);
        chk("start_on_done_ignored", busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {Q, R, busy, done, div_zero}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run(8'd200, 8'd7,   8'd28,  8'd4, 1'b0, 1'b0);
        run(8'd3,   8'd10,  8'd0,   8'd3, 1'b0, 1'b0);
        run(8'd255, 8'd255, 8'd1,   8'd0, 1'b0, 1'b0);
        run(8'd255, 8'd1,   8'd255, 8'd0, 1'b0, 1'b0);
        run(8'd5,   8'd0,   8'hFF,  8'd5, 1'b1, 1'b0);
        run(8'd9,   8'd2,   8'd4,   8'd1, 1'b0, 1'b0);
        run(8'd100, 8'd3,   8'd33,  8'd1, 1'b0, 1'b1);
        run(8'd0,   8'd0,   8'hFF,  8'd0, 1'b1, 1'b0);
        // Abort a division with an asynchronous reset mid-cycle.
        A = 8'd200;
        B = 8'd7;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_reset_outputs", {Q, R, busy, done, div_zero}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1 chk("no_done_after_abort", done, 0);
        end
        run(8'd17, 8'd4, 8'd4, 8'd1, 1'b0, 1'b0);
        for (int a = 0; a < 256; a += 51)
            for (int b = 0; b < 256; b++)
                run(8'(a), 8'(b), b == 0 ? 8'hFF : 8'(a / b), b == 0 ? 8'(a) : 8'(a % b), b == 0, 1'b0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
